// File: rtl/icache_pkg.sv
// Shared types and constants for the instruction cache.
//
// Contents:
//   MEM_COMMAND  - memory command encoding (NONE/LOAD/STORE)
//   MEM_TAG      - memory transaction tag, 0 means "no transaction"
//   MEM_BLOCK    - 64-bit memory block
//   ICACHE_TAG   - per-line address tag for the default geometry
//   NUM_LINES    - default number of cache lines (power of 2)
//   block_addr() - aligns a byte address down to its 8-byte block
package icache_pkg;

  localparam int NUM_LINES       = 32;
  localparam int MEM_TAG_BITS    = 4;
  localparam int OFFSET_BITS     = 3;
  localparam int INDEX_BITS      = $clog2(NUM_LINES);
  localparam int ICACHE_TAG_BITS = 32 - OFFSET_BITS - INDEX_BITS;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } MEM_COMMAND;

  typedef logic [MEM_TAG_BITS-1:0]    MEM_TAG;
  typedef logic [63:0]                MEM_BLOCK;
  typedef logic [ICACHE_TAG_BITS-1:0] ICACHE_TAG;

  function automatic logic [31:0] block_addr(input logic [31:0] addr);
    return {addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_mem.sv
// Line storage for the instruction cache: valid bits, address tags and
// data blocks. One synchronous write port, one asynchronous read port.
// Only the valid bits are reset; tag/data contents are meaningless until
// the matching valid bit is set by a fill.
//
// Ports:
//   clock, reset          - rising-edge clock, async active-low reset
//   wr_en/wr_idx/wr_tag/wr_data - line fill (sets valid)
//   rd_idx                - line to read
//   rd_valid/rd_tag/rd_data     - contents of line rd_idx
module icache_mem #(
  parameter int NUM_LINES = 32,
  parameter int TAG_W     = 24
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [$clog2(NUM_LINES)-1:0] wr_idx,
  input  logic [TAG_W-1:0]             wr_tag,
  input  logic [63:0]                  wr_data,
  input  logic [$clog2(NUM_LINES)-1:0] rd_idx,
  output logic                         rd_valid,
  output logic [TAG_W-1:0]             rd_tag,
  output logic [63:0]                  rd_data
);
  import icache_pkg::*;

  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [TAG_W-1:0]     tag_d  [NUM_LINES];
  MEM_BLOCK             data_q [NUM_LINES];
  MEM_BLOCK             data_d [NUM_LINES];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
      tag_d[wr_idx]   = wr_tag;
      data_d[wr_idx]  = wr_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  always_ff @(posedge clock) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache. Hits are served
// combinationally; a miss issues a single LOAD and the line is filled when
// the memory completes the transaction with the matching tag.
//
// Optional build macro: ICACHE_PERF_COUNTERS_EN adds hit/miss counters.
//
// Ports:
//   clock, reset         - rising-edge clock, async active-low reset
//   Imem2proc_response   - tag assigned to this cycle's request, 0 = refused
//   Imem2proc_data       - completing block data
//   Imem2proc_tag        - tag of the completing transaction, 0 = none
//   proc2Icache_addr     - fetch byte address
//   proc2Imem_command    - NONE or LOAD
//   proc2Imem_addr       - block-aligned miss address, 0 when idle
//   Icache_data_out      - block at the indexed line
//   Icache_valid_out     - hit
//   icache_hit_count     - (macro only) cycles with a hit
//   icache_miss_count    - (macro only) accepted LOADs
module icache #(
  parameter int NUM_LINES    = icache_pkg::NUM_LINES,
  parameter int MEM_TAG_BITS = icache_pkg::MEM_TAG_BITS
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [MEM_TAG_BITS-1:0] Imem2proc_response,
  input  logic [63:0]             Imem2proc_data,
  input  logic [MEM_TAG_BITS-1:0] Imem2proc_tag,
  input  logic [31:0]             proc2Icache_addr,
  output icache_pkg::MEM_COMMAND  proc2Imem_command,
  output logic [31:0]             proc2Imem_addr,
  output logic [63:0]             Icache_data_out,
  output logic                    Icache_valid_out
`ifdef ICACHE_PERF_COUNTERS_EN
  ,
  output logic [31:0]             icache_hit_count,
  output logic [31:0]             icache_miss_count
`endif
);
  import icache_pkg::*;

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 32 - OFFSET_BITS - IDX_W;

  logic [IDX_W-1:0] cur_index;
  logic [TAG_W-1:0] cur_tag;
  logic             unused_offset_bits;

  assign cur_index          = proc2Icache_addr[OFFSET_BITS +: IDX_W];
  assign cur_tag            = proc2Icache_addr[31 -: TAG_W];
  assign unused_offset_bits = ^proc2Icache_addr[OFFSET_BITS-1:0];

  logic             line_valid;
  logic [TAG_W-1:0] line_tag;
  MEM_BLOCK         line_data;

  logic [MEM_TAG_BITS-1:0] pend_tag_q, pend_tag_d;
  logic [IDX_W-1:0]        pend_index_q, pend_index_d;
  logic [TAG_W-1:0]        pend_line_tag_q, pend_line_tag_d;

  logic hit, issue_load, accept, fill;

  always_comb begin
    hit        = line_valid && (line_tag == cur_tag);
    // Gating on reset keeps the command quiet while reset is held even
    // though the pending register is already clear.
    issue_load = !hit && (pend_tag_q == '0) && reset;
    accept     = issue_load && (Imem2proc_response != '0);
    // Completions are only matched against the registered tag, so a
    // same-cycle response carrying the same value cannot fill early.
    fill       = (pend_tag_q != '0) && (Imem2proc_tag == pend_tag_q);

    pend_tag_d      = pend_tag_q;
    pend_index_d    = pend_index_q;
    pend_line_tag_d = pend_line_tag_q;
    // accept and fill are exclusive: accept requires pend_tag_q == 0.
    if (fill) begin
      pend_tag_d = '0;
    end
    if (accept) begin
      pend_tag_d      = Imem2proc_response;
      pend_index_d    = cur_index;
      pend_line_tag_d = cur_tag;
    end

    proc2Imem_command = issue_load ? LOAD : NONE;
    proc2Imem_addr    = issue_load ? block_addr(proc2Icache_addr) : 32'h0;
    Icache_valid_out  = hit;
    Icache_data_out   = line_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_tag_q      <= '0;
      pend_index_q    <= '0;
      pend_line_tag_q <= '0;
    end else begin
      pend_tag_q      <= pend_tag_d;
      pend_index_q    <= pend_index_d;
      pend_line_tag_q <= pend_line_tag_d;
    end
  end

  icache_mem #(
    .NUM_LINES (NUM_LINES),
    .TAG_W     (TAG_W)
  ) u_mem (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (fill),
    .wr_idx   (pend_index_q),
    .wr_tag   (pend_line_tag_q),
    .wr_data  (Imem2proc_data),
    .rd_idx   (cur_index),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data)
  );

`ifdef ICACHE_PERF_COUNTERS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit    ? hit_count_q + 32'd1  : hit_count_q;
    miss_count_d = accept ? miss_count_q + 32'd1 : miss_count_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign icache_hit_count  = hit_count_q;
  assign icache_miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache.sv
module tb_icache;
  import icache_pkg::*;

  logic        clock;
  logic        reset;
  logic [3:0]  Imem2proc_response;
  logic [63:0] Imem2proc_data;
  logic [3:0]  Imem2proc_tag;
  logic [31:0] proc2Icache_addr;
  MEM_COMMAND  proc2Imem_command;
  logic [31:0] proc2Imem_addr;
  logic [63:0] Icache_data_out;
  logic        Icache_valid_out;
`ifdef ICACHE_PERF_COUNTERS_EN
  logic [31:0] icache_hit_count;
  logic [31:0] icache_miss_count;
`endif

  icache dut (
    .clock              (clock),
    .reset              (reset),
    .Imem2proc_response (Imem2proc_response),
    .Imem2proc_data     (Imem2proc_data),
    .Imem2proc_tag      (Imem2proc_tag),
    .proc2Icache_addr   (proc2Icache_addr),
    .proc2Imem_command  (proc2Imem_command),
    .proc2Imem_addr     (proc2Imem_addr),
    .Icache_data_out    (Icache_data_out),
    .Icache_valid_out   (Icache_valid_out)
`ifdef ICACHE_PERF_COUNTERS_EN
    ,
    .icache_hit_count   (icache_hit_count),
    .icache_miss_count  (icache_miss_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One cycle of stimulus plus the outputs expected in that same cycle.
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  resp;
    logic [3:0]  mtag;
    logic [63:0] mdata;
    logic        exp_valid;
    logic        chk_data;
    logic [63:0] exp_data;
    MEM_COMMAND  exp_cmd;
    logic [31:0] exp_maddr;
  } row_t;

  row_t sb[$];
  row_t e;
  int   total = 0;
  int   bad   = 0;

  localparam logic [63:0] D1 = 64'hdeadbeefcafebabe;
  localparam logic [63:0] D2 = 64'h0123456789abcdef;
  localparam logic [63:0] D3 = 64'h3333_4444_5555_6666;
  localparam logic [63:0] D4 = 64'h4444_aaaa_bbbb_cccc;
  localparam logic [63:0] D5 = 64'h5555_0000_ffff_1234;
  localparam logic [63:0] D6 = 64'h6666_1212_3434_5656;
  localparam logic [63:0] D7 = 64'h7777_9999_8888_0001;

  function automatic row_t r(input logic [31:0] addr, input int resp, input int mtag,
                             input logic [63:0] mdata, input bit v, input bit cd,
                             input logic [63:0] d, input MEM_COMMAND cmd,
                             input logic [31:0] maddr);
    row_t x;
    x.addr = addr; x.resp = 4'(resp); x.mtag = 4'(mtag); x.mdata = mdata;
    x.exp_valid = v; x.chk_data = cd; x.exp_data = d; x.exp_cmd = cmd; x.exp_maddr = maddr;
    return x;
  endfunction

  task automatic apply_row(input row_t x);
    proc2Icache_addr   = x.addr;
    Imem2proc_response = x.resp;
    Imem2proc_tag      = x.mtag;
    Imem2proc_data     = x.mdata;
    sb.push_back(x);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    proc2Icache_addr = 32'h0; Imem2proc_response = '0; Imem2proc_tag = '0; Imem2proc_data = '0;
    @(negedge clock); #1;
    total++;
    if (Icache_valid_out !== 1'b0 || proc2Imem_command !== NONE || proc2Imem_addr !== 32'h0) begin
      bad++;
      $display("FAIL reset_idle: got valid=%b cmd=%0d addr=%h, want valid=0 cmd=0 addr=0",
               Icache_valid_out, proc2Imem_command, proc2Imem_addr);
    end
    proc2Icache_addr = 32'h400; #1;
    total++;
    if (proc2Imem_command !== NONE || proc2Imem_addr !== 32'h0) begin
      bad++;
      $display("FAIL reset_quiet: got cmd=%0d addr=%h, want cmd=0 addr=0",
               proc2Imem_command, proc2Imem_addr);
    end
    @(negedge clock);
    reset = 1'b1;
    apply_row(r(32'h0, 0, 0, 64'h0, 0, 0, 64'h0, LOAD, 32'h0));
    #1; e = sb.pop_front();
    total++;
    if (Icache_valid_out !== e.exp_valid || proc2Imem_command !== e.exp_cmd || proc2Imem_addr !== e.exp_maddr) begin
      bad++;
      $display("FAIL reset_release: got valid=%b cmd=%0d addr=%h, want valid=%b cmd=%0d addr=%h",
               Icache_valid_out, proc2Imem_command, proc2Imem_addr, e.exp_valid, e.exp_cmd, e.exp_maddr);
    end
  endtask

  task automatic test_cold_miss();
    row_t rows[$];
    rows.push_back(r(32'h400, 1, 1, D1, 0, 0, 0, LOAD, 32'h400));
    rows.push_back(r(32'h400, 1, 1, D1, 0, 0, 0, NONE, 32'h0));
    rows.push_back(r(32'h400, 1, 1, D1, 1, 1, D1, NONE, 32'h0));
    foreach (rows[i]) begin
      @(negedge clock); apply_row(rows[i]); #1; e = sb.pop_front();
      total++;
      if (Icache_valid_out !== e.exp_valid || proc2Imem_command !== e.exp_cmd || proc2Imem_addr !== e.exp_maddr) begin
        bad++;
        $display("FAIL cold_miss[%0d]: got valid=%b cmd=%0d addr=%h, want valid=%b cmd=%0d addr=%h", i,
                 Icache_valid_out, proc2Imem_command, proc2Imem_addr, e.exp_valid, e.exp_cmd, e.exp_maddr);
      end
      if (e.chk_data) begin
        total++;
        if (Icache_data_out !== e.exp_data) begin
          bad++;
          $display("FAIL cold_miss[%0d] data: got %h want %h", i, Icache_data_out, e.exp_data);
        end
      end
    end
  endtask

  task automatic test_hit_reuse();
    row_t rows[$];
    rows.push_back(r(32'h400, 0, 0, 64'h0, 1, 1, D1, NONE, 32'h0));
    rows.push_back(r(32'h404, 0, 0, 64'h0, 1, 1, D1, NONE, 32'h0));
    rows.push_back(r(32'h407, 0, 0, 64'h0, 1, 1, D1, NONE, 32'h0));
    foreach (rows[i]) begin
      @(negedge clock); apply_row(rows[i]); #1; e = sb.pop_front();
      total++;
      if (Icache_valid_out !== e.exp_valid || proc2Imem_command !== e.exp_cmd || proc2Imem_addr !== e.exp_maddr) begin
        bad++;
        $display("FAIL hit_reuse[%0d]: got valid=%b cmd=%0d addr=%h, want valid=%b cmd=%0d addr=%h", i,
                 Icache_valid_out, proc2Imem_command, proc2Imem_addr, e.exp_valid, e.exp_cmd, e.exp_maddr);
      end
      if (e.chk_data) begin
        total++;
        if (Icache_data_out !== e.exp_data) begin
          bad++;
          $display("FAIL hit_reuse[%0d] data: got %h want %h", i, Icache_data_out, e.exp_data);
        end
      end
    end
  endtask

  task automatic test_retry();
    row_t rows[$];
    for (int k = 0; k < 3; k++) rows.push_back(r(32'h800, 0, 0, 64'h0, 0, 0, 0, LOAD, 32'h800));
    rows.push_back(r(32'h800, 2, 0, 64'h0, 0, 0, 0, LOAD, 32'h800));
    rows.push_back(r(32'h800, 0, 2, D2, 0, 0, 0, NONE, 32'h0));
    rows.push_back(r(32'h800, 0, 0, 64'h0, 1, 1, D2, NONE, 32'h0));
    foreach (rows[i]) begin
      @(negedge clock); apply_row(rows[i]); #1; e = sb.pop_front();
      total++;
      if (Icache_valid_out !== e.exp_valid || proc2Imem_command !== e.exp_cmd || proc2Imem_addr !== e.exp_maddr) begin
        bad++;
        $display("FAIL retry[%0d]: got valid=%b cmd=%0d addr=%h, want valid=%b cmd=%0d addr=%h", i,
                 Icache_valid_out, proc2Imem_command, proc2Imem_addr, e.exp_valid, e.exp_cmd, e.exp_maddr);
      end
      if (e.chk_data) begin
        total++;
        if (Icache_data_out !== e.exp_data) begin
          bad++;
          $display("FAIL retry[%0d] data: got %h want %h", i, Icache_data_out, e.exp_data);
        end
      end
    end
  endtask

  task automatic test_conflict();
    row_t rows[$];
    rows.push_back(r(32'h400, 4, 0, 64'h0, 0, 0, 0, LOAD, 32'h400));
    rows.push_back(r(32'h400, 0, 4, D3, 0, 0, 0, NONE, 32'h0));
    rows.push_back(r(32'h400, 0, 0, 64'h0, 1, 1, D3, NONE, 32'h0));
    rows.push_back(r(32'h500, 5, 0, 64'h0, 0, 0, 0, LOAD, 32'h500));
    rows.push_back(r(32'h500, 0, 5, D4, 0, 0, 0, NONE, 32'h0));
    rows.push_back(r(32'h500, 0, 0, 64'h0, 1, 1, D4, NONE, 32'h0));
    rows.push_back(r(32'h400, 0, 0, 64'h0, 0, 0, 0, LOAD, 32'h400));
    foreach (rows[i]) begin
      @(negedge clock); apply_row(rows[i]); #1; e = sb.pop_front();
      total++;
      if (Icache_valid_out !== e.exp_valid || proc2Imem_command !== e.exp_cmd || proc2Imem_addr !== e.exp_maddr) begin
        bad++;
        $display("FAIL conflict[%0d]: got valid=%b cmd=%0d addr=%h, want valid=%b cmd=%0d addr=%h", i,
                 Icache_valid_out, proc2Imem_command, proc2Imem_addr, e.exp_valid, e.exp_cmd, e.exp_maddr);
      end
      if (e.chk_data) begin
        total++;
        if (Icache_data_out !== e.exp_data) begin
          bad++;
          $display("FAIL conflict[%0d] data: got %h want %h", i, Icache_data_out, e.exp_data);
        end
      end
    end
  endtask

  task automatic test_foreign_tag();
    row_t rows[$];
    rows.push_back(r(32'h408, 3, 0, 64'h0, 0, 0, 0, LOAD, 32'h408));
    rows.push_back(r(32'h408, 0, 5, 64'h1111, 0, 0, 0, NONE, 32'h0));
    rows.push_back(r(32'h408, 0, 0, 64'h0, 0, 0, 0, NONE, 32'h0));
    rows.push_back(r(32'h408, 0, 3, D5, 0, 0, 0, NONE, 32'h0));
    rows.push_back(r(32'h408, 0, 0, 64'h0, 1, 1, D5, NONE, 32'h0));
    foreach (rows[i]) begin
      @(negedge clock); apply_row(rows[i]); #1; e = sb.pop_front();
      total++;
      if (Icache_valid_out !== e.exp_valid || proc2Imem_command !== e.exp_cmd || proc2Imem_addr !== e.exp_maddr) begin
        bad++;
        $display("FAIL foreign_tag[%0d]: got valid=%b cmd=%0d addr=%h, want valid=%b cmd=%0d addr=%h", i,
                 Icache_valid_out, proc2Imem_command, proc2Imem_addr, e.exp_valid, e.exp_cmd, e.exp_maddr);
      end
      if (e.chk_data) begin
        total++;
        if (Icache_data_out !== e.exp_data) begin
          bad++;
          $display("FAIL foreign_tag[%0d] data: got %h want %h", i, Icache_data_out, e.exp_data);
        end
      end
    end
  endtask

  task automatic test_addr_change_pending();
    row_t rows[$];
    rows.push_back(r(32'h410, 6, 0, 64'h0, 0, 0, 0, LOAD, 32'h410));
    rows.push_back(r(32'h418, 7, 0, 64'h0, 0, 0, 0, NONE, 32'h0));
    rows.push_back(r(32'h418, 0, 6, D6, 0, 0, 0, NONE, 32'h0));
    rows.push_back(r(32'h418, 0, 0, 64'h0, 0, 0, 0, LOAD, 32'h418));
    rows.push_back(r(32'h410, 0, 0, 64'h0, 1, 1, D6, NONE, 32'h0));
    foreach (rows[i]) begin
      @(negedge clock); apply_row(rows[i]); #1; e = sb.pop_front();
      total++;
      if (Icache_valid_out !== e.exp_valid || proc2Imem_command !== e.exp_cmd || proc2Imem_addr !== e.exp_maddr) begin
        bad++;
        $display("FAIL addr_change[%0d]: got valid=%b cmd=%0d addr=%h, want valid=%b cmd=%0d addr=%h", i,
                 Icache_valid_out, proc2Imem_command, proc2Imem_addr, e.exp_valid, e.exp_cmd, e.exp_maddr);
      end
      if (e.chk_data) begin
        total++;
        if (Icache_data_out !== e.exp_data) begin
          bad++;
          $display("FAIL addr_change[%0d] data: got %h want %h", i, Icache_data_out, e.exp_data);
        end
      end
    end
  endtask

  task automatic test_same_cycle_tag();
    row_t rows[$];
    rows.push_back(r(32'h428, 7, 7, D7, 0, 0, 0, LOAD, 32'h428));
    rows.push_back(r(32'h428, 0, 0, 64'h0, 0, 0, 0, NONE, 32'h0));
    rows.push_back(r(32'h428, 0, 7, D7, 0, 0, 0, NONE, 32'h0));
    rows.push_back(r(32'h428, 0, 0, 64'h0, 1, 1, D7, NONE, 32'h0));
    foreach (rows[i]) begin
      @(negedge clock); apply_row(rows[i]); #1; e = sb.pop_front();
      total++;
      if (Icache_valid_out !== e.exp_valid || proc2Imem_command !== e.exp_cmd || proc2Imem_addr !== e.exp_maddr) begin
        bad++;
        $display("FAIL same_cycle[%0d]: got valid=%b cmd=%0d addr=%h, want valid=%b cmd=%0d addr=%h", i,
                 Icache_valid_out, proc2Imem_command, proc2Imem_addr, e.exp_valid, e.exp_cmd, e.exp_maddr);
      end
      if (e.chk_data) begin
        total++;
        if (Icache_data_out !== e.exp_data) begin
          bad++;
          $display("FAIL same_cycle[%0d] data: got %h want %h", i, Icache_data_out, e.exp_data);
        end
      end
    end
  endtask

  task automatic test_reset_mid_miss();
    row_t pre[$];
    row_t post[$];
    pre.push_back(r(32'h420, 6, 0, 64'h0, 0, 0, 0, LOAD, 32'h420));
    pre.push_back(r(32'h420, 0, 0, 64'h0, 0, 0, 0, NONE, 32'h0));
    foreach (pre[i]) begin
      @(negedge clock); apply_row(pre[i]); #1; e = sb.pop_front();
      total++;
      if (Icache_valid_out !== e.exp_valid || proc2Imem_command !== e.exp_cmd || proc2Imem_addr !== e.exp_maddr) begin
        bad++;
        $display("FAIL reset_mid_pre[%0d]: got valid=%b cmd=%0d addr=%h, want valid=%b cmd=%0d addr=%h", i,
                 Icache_valid_out, proc2Imem_command, proc2Imem_addr, e.exp_valid, e.exp_cmd, e.exp_maddr);
      end
    end
    // Line 2 (0x410) is valid here; asserting reset between edges must drop it at once.
    proc2Icache_addr = 32'h410;
    #1;
    total++;
    if (Icache_valid_out !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_prehit: got valid=%b want 1", Icache_valid_out);
    end
    #1 reset = 1'b0;
    #1;
    total++;
    if (Icache_valid_out !== 1'b0 || proc2Imem_command !== NONE || proc2Imem_addr !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid_async: got valid=%b cmd=%0d addr=%h, want valid=0 cmd=0 addr=0",
               Icache_valid_out, proc2Imem_command, proc2Imem_addr);
    end
    post.push_back(r(32'h420, 0, 6, D6, 0, 0, 0, LOAD, 32'h420));
    post.push_back(r(32'h420, 0, 0, 64'h0, 0, 0, 0, LOAD, 32'h420));
    post.push_back(r(32'h410, 0, 0, 64'h0, 0, 0, 0, LOAD, 32'h410));
    post.push_back(r(32'h500, 0, 0, 64'h0, 0, 0, 0, LOAD, 32'h500));
    foreach (post[i]) begin
      @(negedge clock);
      reset = 1'b1;
      apply_row(post[i]); #1; e = sb.pop_front();
      total++;
      if (Icache_valid_out !== e.exp_valid || proc2Imem_command !== e.exp_cmd || proc2Imem_addr !== e.exp_maddr) begin
        bad++;
        $display("FAIL reset_mid_post[%0d]: got valid=%b cmd=%0d addr=%h, want valid=%b cmd=%0d addr=%h", i,
                 Icache_valid_out, proc2Imem_command, proc2Imem_addr, e.exp_valid, e.exp_cmd, e.exp_maddr);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cold_miss();
    test_hit_reuse();
    test_retry();
    test_conflict();
    test_foreign_tag();
    test_addr_change_pending();
    test_same_cycle_tag();
    test_reset_mid_miss();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
